// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ripple ALU: decodes R-type instructions, reads a 32x32
// register file, drives the ALU operand/function pins, samples its result and writes back.
module alu_issue_ctrl #(
  parameter int unsigned ALU_SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  signal,
  output logic        alu_reset,
  input  logic [31:0] alu_dataOut,
  output logic        done,
  output logic        illegal,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OPR  = 2'd1;
  localparam logic [1:0] EXE  = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] SETTLE_LAST = 4'(ALU_SETTLE - 1);

  logic [1:0]  state;
  logic [4:0]  ir_rs;
  logic [4:0]  ir_rt;
  logic [4:0]  ir_rd;
  logic [5:0]  ir_funct;
  logic [3:0]  cnt;
  logic        illegal_q;
  logic [31:0] rf [32];

  // The shift amount field has no meaning for the supported functions.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  function automatic logic is_legal(input logic [31:0] i);
    return (i[31:26] == 6'b000000) &&
           (i[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
  endfunction

  assign instr_ready = (state == IDLE);
  assign alu_reset   = (state != EXE);
  assign done        = (state == WB);
  assign illegal     = illegal_q;
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'h0 : rf[dbg_addr];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation/synthesis mismatch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ir_rs     <= '0;
      ir_rt     <= '0;
      ir_rd     <= '0;
      ir_funct  <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
      dataA     <= '0;
      dataB     <= '0;
      signal    <= '0;
      result    <= '0;
      // NOTE: the register file must read all-zero after reset, so it is built from
      // resettable flops rather than an inferred RAM macro.
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Preload lands at this edge, so the OPR read one cycle later already sees it.
          if (wr_en && wr_addr != 5'd0) rf[wr_addr] <= wr_data;
          if (instr_valid) begin
            ir_rs    <= instr[25:21];
            ir_rt    <= instr[20:16];
            ir_rd    <= instr[15:11];
            ir_funct <= instr[5:0];
            if (is_legal(instr)) begin
              state <= OPR;
            end else begin
              state     <= WB;
              illegal_q <= 1'b1;
            end
          end
        end
        OPR: begin
          dataA  <= (ir_rs == 5'd0) ? 32'h0 : rf[ir_rs];
          dataB  <= (ir_rt == 5'd0) ? 32'h0 : rf[ir_rt];
          signal <= ir_funct;
          cnt    <= '0;
          state  <= EXE;
        end
        EXE: begin
          if (cnt == SETTLE_LAST) begin
            result <= alu_dataOut;
            state  <= WB;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WB: begin
          if (!illegal_q && ir_rd != 5'd0) rf[ir_rd] <= result;
          illegal_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: two instances (ALU_SETTLE 1 and 4), each with a
// ripple-ALU model that only produces the right answer once it has settled.
module tb_alu_issue_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid0, valid1;
  logic [31:0] instr;
  logic        wr_en;
  logic [4:0]  wr_addr, dbg_addr;
  logic [31:0] wr_data;

  logic        ready0, ready1, ar0, ar1, done0, done1, ill0, ill1;
  logic [31:0] dbg0, dbg1, a0, a1, b0, b1, res0, res1, aout0, aout1;
  logic [5:0]  sig0, sig1;

  int tests = 0;
  int fails = 0;
  int acnt0 = 0;
  int acnt1 = 0;

  logic [31:0] model [2][32];
  logic [31:0] last_res [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] s);
    case (s)
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return 32'h0;
    endcase
  endfunction

  // Ripple ALU: wrong (inverted) answer until it has been out of reset for S cycles.
  always @(posedge clk) acnt0 <= ar0 ? 0 : acnt0 + 1;
  always @(posedge clk) acnt1 <= ar1 ? 0 : acnt1 + 1;
  assign aout0 = ar0 ? 32'h0 : (acnt0 >= S0 - 1 ? alu_f(a0, b0, sig0) : ~alu_f(a0, b0, sig0));
  assign aout1 = ar1 ? 32'h0 : (acnt1 >= S1 - 1 ? alu_f(a1, b1, sig1) : ~alu_f(a1, b1, sig1));

  alu_issue_ctrl #(.ALU_SETTLE(S0)) u0 (
    .clk(clk), .reset(reset), .instr_valid(valid0), .instr(instr), .instr_ready(ready0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg0), .dataA(a0), .dataB(b0), .signal(sig0), .alu_reset(ar0),
    .alu_dataOut(aout0), .done(done0), .illegal(ill0), .result(res0)
  );

  alu_issue_ctrl #(.ALU_SETTLE(S1)) u1 (
    .clk(clk), .reset(reset), .instr_valid(valid1), .instr(instr), .instr_ready(ready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg1), .dataA(a1), .dataB(b1), .signal(sig1), .alu_reset(ar1),
    .alu_dataOut(aout1), .done(done1), .illegal(ill1), .result(res1)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input int rs, input int rt,
                                      input int rd, input logic [5:0] f);
    logic [31:0] w;
    w = {op, 5'(rs), 5'(rt), 5'(rd), 5'($urandom_range(31)), f};
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) model[d][r] = 32'h0;
      last_res[d] = 32'h0;
    end
  endtask

  // Preload while both instances are idle; address 0 is never writable.
  task automatic preload(input int addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr != 0) begin
      model[0][addr] = data;
      model[1][addr] = data;
    end
  endtask

  // wr_mode: 0 none, 1 preload in the accept cycle, 2 preload one cycle later (d is busy).
  task automatic run(input int d, input logic [31:0] ins, input int wr_mode,
                     input int waddr, input logic [31:0] wdata);
    int rs, rt, rd, lat, exp_lat;
    logic legal, saw_low;
    logic [31:0] exp_res;
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    legal = (ins[31:26] == 6'b0) &&
            (ins[5:0] inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
    @(negedge clk);
    check("ready_before", d ? ready1 : ready0, 1);
    instr = ins;
    if (d == 0) valid0 = 1'b1; else valid1 = 1'b1;
    if (wr_mode == 1) begin
      wr_en = 1'b1; wr_addr = 5'(waddr); wr_data = wdata;
      if (waddr != 0) begin
        model[0][waddr] = wdata;
        model[1][waddr] = wdata;
      end
    end
    exp_lat = legal ? (d ? S1 : S0) + 2 : 1;
    exp_res = legal ? alu_f(model[d][rs], model[d][rt], ins[5:0]) : last_res[d];
    lat = 0;
    saw_low = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid0 = 1'b0; valid1 = 1'b0; wr_en = 1'b0;
        if (wr_mode == 2) begin
          wr_en = 1'b1; wr_addr = 5'(waddr); wr_data = wdata;
          if (waddr != 0) model[1-d][waddr] = wdata;
        end
      end
      if (c == 2) wr_en = 1'b0;
      if (!(d ? ar1 : ar0)) saw_low = 1'b1;
      if (d ? done1 : done0) begin
        lat = c;
        break;
      end
    end
    wr_en = 1'b0;
    check("latency", lat, exp_lat);
    check("illegal", d ? ill1 : ill0, !legal);
    check("result", d ? res1 : res0, exp_res);
    check("alu_reset_low", saw_low, legal);
    if (legal && rd != 0) model[d][rd] = exp_res;
    last_res[d] = exp_res;
    @(negedge clk);
    check("done_pulse", d ? done1 : done0, 0);
    dbg_addr = 5'(rd);
    #1;
    check("dbg_rd", d ? dbg1 : dbg0, model[d][rd]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins;
    int d, f_sel;
    logic [5:0] fc [5];
    fc = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b0; valid0 = 1'b0; valid1 = 1'b0; instr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    clear_model();
    #1;
    check("rst_ready", ready0, 1);
    check("rst_alu_reset", ar1, 1);
    check("rst_done", done0, 0);
    check("rst_result", res1, 0);
    check("rst_signal", sig0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic arithmetic on the settle-1 instance.
    preload(1, 32'd5);
    preload(2, 32'd7);
    run(0, enc(6'b0, 1, 2, 3, 6'b100000), 0, 0, 0);
    run(0, enc(6'b0, 1, 2, 4, 6'b100010), 0, 0, 0);
    run(0, enc(6'b0, 2, 1, 6, 6'b100010), 0, 0, 0);
    preload(5, 32'hFFFF_FFFF);
    run(0, enc(6'b0, 5, 1, 7, 6'b101010), 0, 0, 0);
    run(0, enc(6'b0, 1, 5, 7, 6'b101010), 0, 0, 0);
    run(0, enc(6'b0, 1, 2, 8, 6'b100100), 0, 0, 0);
    run(0, enc(6'b0, 1, 2, 8, 6'b100101), 0, 0, 0);

    // Register 0 is hard-wired to zero.
    run(0, enc(6'b0, 1, 2, 0, 6'b100000), 0, 0, 0);
    preload(0, 32'd9);
    dbg_addr = 5'd0;
    #1;
    check("r0_zero", dbg0, 0);

    // Rejected instructions.
    run(0, enc(6'b0, 1, 2, 9, 6'b000000), 0, 0, 0);
    run(0, enc(6'b000001, 1, 2, 9, 6'b100000), 0, 0, 0);

    // Preload in the accept cycle is visible to the operand read.
    run(0, enc(6'b0, 1, 2, 9, 6'b100000), 1, 1, 32'd100);
    // Preload while busy is dropped by the busy instance only.
    run(0, enc(6'b0, 1, 2, 10, 6'b100000), 2, 11, 32'hDEAD);
    dbg_addr = 5'd11;
    #1;
    check("busy_wr_ignored", dbg0, model[0][11]);
    check("idle_wr_taken", dbg1, model[1][11]);

    // Longer settle time.
    run(1, enc(6'b0, 1, 2, 3, 6'b100000), 0, 0, 0);

    // Reset while the settle-4 instance is executing.
    @(negedge clk);
    instr = enc(6'b0, 1, 2, 12, 6'b100000);
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_exe", ar1, 0);
    reset = 1'b0;
    #1;
    check("rst_exe_alu_reset", ar1, 1);
    check("rst_exe_ready", ready1, 1);
    check("rst_exe_dataA", a1, 0);
    check("rst_exe_result", res1, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_done", done1, 0);
    end
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    check("rst_rel_ready", ready1, 1);
    dbg_addr = 5'd3;
    #1;
    check("rst_rf0_clear", dbg0, 0);
    check("rst_rf1_clear", dbg1, 0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(2) == 0)
        preload(int'($urandom_range(31)), $urandom_range(3) == 0 ? 32'h8000_0000 | $urandom : $urandom);
      d = int'($urandom_range(1));
      f_sel = int'($urandom_range(4));
      ins = enc(($urandom_range(19) == 0) ? 6'(1 + $urandom_range(62)) : 6'b0,
                int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
                ($urandom_range(9) == 0) ? 6'($urandom) : fc[f_sel]);
      if ($urandom_range(4) == 0)
        run(d, ins, 1, int'($urandom_range(31)), $urandom);
      else
        run(d, ins, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
